// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default timing constants for button debouncers.
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 1_000_000;
  localparam int unsigned REPEAT_TICKS_DEF   = 25_000_000;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: SYNC_STAGES-deep flop chain bringing an asynchronous input into the clk domain.
module btn_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: pushbutton debouncer producing a clean level plus press/release pulses.
// Define BTN_AUTO_REPEAT_EN to re-issue press_o every REPEAT_TICKS clocks while held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);
  if (DEBOUNCE_TICKS < 2 || SYNC_STAGES < 2 || REPEAT_TICKS < 2) begin : g_bad_param
    $error("btn_debounce: parameters must be at least 2");
  end
  logic sync_q;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_d, press_d, release_d, rpt_hit;
  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_i),
    .q_o   (sync_q)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: if (sync_q) begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
      WAIT_HIGH: if (!sync_q) state_d = IDLE_LOW;
        else if (cnt_q == CNT_MAX) state_d = IDLE_HIGH;
        else cnt_d = cnt_q + 1'b1;
      IDLE_HIGH: if (!sync_q) begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
      WAIT_LOW: if (sync_q) state_d = IDLE_HIGH;
        else if (cnt_q == CNT_MAX) state_d = IDLE_LOW;
        else cnt_d = cnt_q + 1'b1;
    endcase
    level_d   = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    press_d   = ((state_q == WAIT_HIGH) && (state_d == IDLE_HIGH)) || rpt_hit;
    release_d = (state_q == WAIT_LOW) && (state_d == IDLE_LOW);
  end
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rpt_q, rpt_d;
  // rpt holds through WAIT_LOW so a bounced release does not restart the repeat period
  always_comb begin
    rpt_hit = (state_q == IDLE_HIGH) && (rpt_q == RPT_MAX);
    rpt_d   = (((state_q == WAIT_HIGH) && (state_d == IDLE_HIGH)) || rpt_hit) ? '0 :
              (state_q == IDLE_HIGH) ? rpt_q + 1'b1 : rpt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_o   <= level_d;
      press_o   <= press_d;
      release_o <= release_d;
    end
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed and random checks of btn_debounce against a run-length model.
module tb_btn_debounce;
  localparam int D  = 4;
  localparam int SS = 2;
  localparam int R  = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_i = 1'b0;
  logic level_o, press_o, release_o;
  int tests = 0;
  int fails = 0;
  int ec, press_cnt, rel_cnt, first_press, first_rel;
  bit hi_seen, lo_seen;
  logic [SS-1:0] m_hist;
  bit m_lvl, m_p, m_r, m_valid;
  int m_run, m_rpt;
  btn_debounce #(.DEBOUNCE_TICKS(D), .SYNC_STAGES(SS), .REPEAT_TICKS(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (btn_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask
  // A change is accepted once the synchronized input has differed from the
  // accepted level on D+1 consecutive clock edges.
  task automatic model_step(input logic b, input logic r);
    bit s;
    if (r) begin
      m_hist = '0; m_lvl = 0; m_run = 0; m_p = 0; m_r = 0; m_rpt = 0; m_valid = 1;
      return;
    end
    s = m_hist[SS-1];
    m_hist = {m_hist[SS-2:0], b};
    m_p = 0;
    m_r = 0;
`ifdef BTN_AUTO_REPEAT_EN
    if (m_lvl && m_run == 0) begin
      if (m_rpt == R - 1) begin m_p = 1; m_rpt = 0; end
      else m_rpt++;
    end
`endif
    m_run = (s != m_lvl) ? m_run + 1 : 0;
    if (m_run == D + 1) begin
      m_lvl = ~m_lvl;
      m_run = 0;
      m_p = m_lvl;
      m_r = !m_lvl;
      if (m_lvl) m_rpt = 0;
    end
  endtask
  task automatic tick(input logic b, input logic r);
    @(negedge clk);
    if (m_valid) begin
      chk("level", level_o, m_lvl);
      chk("press", press_o, m_p);
      chk("release", release_o, m_r);
      chk("press_release_excl", press_o & release_o, 0);
    end
    if (press_o === 1'b1) begin press_cnt++; if (first_press < 0) first_press = ec; end
    if (release_o === 1'b1) begin rel_cnt++; if (first_rel < 0) first_rel = ec; end
    if (level_o === 1'b1) hi_seen = 1;
    if (level_o === 1'b0) lo_seen = 1;
    btn_i = b;
    reset = r;
    model_step(b, r);
    ec++;
  endtask
  task automatic mark();
    ec = 0; press_cnt = 0; rel_cnt = 0; first_press = -1; first_rel = -1;
    hi_seen = 0; lo_seen = 0;
  endtask
  task automatic run(input logic b, input int n);
    repeat (n) tick(b, 1'b0);
  endtask
  initial begin
    m_valid = 0; m_hist = '0; m_lvl = 0; m_run = 0; m_rpt = 0; m_p = 0; m_r = 0;
    mark();
    repeat (3) tick(1'b0, 1'b1);
    mark();
    run(1'b0, 20);
    chk("reset_idle_activity", {29'd0, hi_seen, press_cnt != 0, rel_cnt != 0}, 0);
    mark();
    run(1'b1, 12);
    chk("press_edge", first_press, 7);
    chk("press_count", press_cnt, 1);
    chk("level_held", level_o, 1);
    mark();
    run(1'b0, 12);
    chk("release_edge", first_rel, 7);
    chk("release_count", rel_cnt, 1);
    mark();
    run(1'b1, 3); run(1'b0, 1); run(1'b1, 3); run(1'b0, 10);
    chk("glitch_press", press_cnt, 0);
    chk("glitch_level", hi_seen, 0);
    run(1'b1, 12);
    mark();
    run(1'b0, 2); run(1'b1, 12);
    chk("dip_release", rel_cnt, 0);
    chk("dip_level", lo_seen, 0);
`ifndef BTN_AUTO_REPEAT_EN
    chk("dip_press", press_cnt, 0);
`endif
    run(1'b0, 12);
    mark();
    run(1'b1, 4);
    tick(1'b1, 1'b1);
    chk("pre_reset_press", press_cnt, 0);
    mark();
    run(1'b1, 12);
    chk("post_reset_press_edge", first_press, 7);
    chk("post_reset_press_count", press_cnt, 1);
    run(1'b0, 12);
    mark();
    run(1'b1, 40);
`ifndef BTN_AUTO_REPEAT_EN
    chk("held_single_press", press_cnt, 1);
`endif
    run(1'b0, 12);
    repeat (300) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) tick(b, 1'($urandom_range(0, 59) == 0));
    end
    run(1'b0, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
